// File: rtl/fcb_csr_regfile.sv
// CSR bank behind the FCB APB slave front-end: control/status/scratch/ID
// registers plus the window-write engine that masks further writes while a window is held.
module fcb_csr_regfile #(
  parameter logic [31:0] ID_VALUE = 32'hFCB0_0001,
  parameter logic [7:0]  WAIT_RST = 8'd3
) (
  input  logic        FCB_CLK,
  input  logic        FCB_RST,
  input  logic [66:0] APBS_CSR_wdata,
  output logic [31:0] CSR_APBS_prdata,
  output logic        CFG_APBS_fmask_win_write_operation,
  output logic        CSR_WIN_wr_valid,
  output logic [31:0] CSR_WIN_wr_data
);

  localparam logic [5:0] IDX_CTRL    = 6'd0;
  localparam logic [5:0] IDX_STATUS  = 6'd1;
  localparam logic [5:0] IDX_SCRATCH = 6'd2;
  localparam logic [5:0] IDX_WIN     = 6'd3;
  localparam logic [5:0] IDX_ID      = 6'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } win_state_e;

  logic        psel_s;
  logic        pwrite_s;
  logic        penable_s;
  logic [31:0] paddr_s;
  logic [31:0] pwdata_s;
  logic [5:0]  idx_s;
  logic        wr_acc_s;
  logic        ctrl_hit_s;
  logic        scratch_hit_s;
  logic        win_hit_s;
  logic        err_hit_s;
  logic        cnt_clr_s;
  logic        win_start_s;
  logic        win_busy_s;
  logic [31:0] prdata_s;
  logic        unused_s;

  logic        win_en_r;
  logic [7:0]  win_wait_r;
  logic [31:0] scratch_r;
  logic        wr_err_r;
  logic [15:0] wr_count_r;
  win_state_e  state_r;
  logic [7:0]  cnt_r;
  logic        fmask_r;
  logic        wr_valid_r;
  logic [31:0] wr_data_r;

  assign psel_s    = APBS_CSR_wdata[66];
  assign pwrite_s  = APBS_CSR_wdata[65];
  assign penable_s = APBS_CSR_wdata[64];
  assign paddr_s   = APBS_CSR_wdata[63:32];
  assign pwdata_s  = APBS_CSR_wdata[31:0];
  assign idx_s     = paddr_s[7:2];
  assign unused_s  = ^{paddr_s[31:8], paddr_s[1:0]};

  // The mask itself blocks acceptance, so no write can land while a window is held.
  assign wr_acc_s    = psel_s & penable_s & pwrite_s & ~fmask_r;
  assign cnt_clr_s   = ctrl_hit_s & pwdata_s[1];
  assign win_start_s = win_hit_s & (state_r != ST_HOLD);
  assign win_busy_s  = (state_r == ST_HOLD);

  // Write decode: which register an accepted write targets, or whether it is an error.
  always_comb begin
    ctrl_hit_s    = 1'b0;
    scratch_hit_s = 1'b0;
    win_hit_s     = 1'b0;
    err_hit_s     = 1'b0;
    if (wr_acc_s) begin
      case (idx_s)
        IDX_CTRL:    ctrl_hit_s    = 1'b1;
        IDX_SCRATCH: scratch_hit_s = 1'b1;
        IDX_WIN: begin
          if (win_en_r) begin
            win_hit_s = 1'b1;
          end else begin
            err_hit_s = 1'b1;
          end
        end
        default:     err_hit_s     = 1'b1;
      endcase
    end else begin
      err_hit_s = 1'b0;
    end
  end

  // Read mux over current register values; deselected or unmapped reads return zero.
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (psel_s) begin
      case (idx_s)
        IDX_CTRL:    prdata_s = {16'h0000, win_wait_r, 7'h00, win_en_r};
        IDX_STATUS:  prdata_s = {wr_count_r, 14'h0000, wr_err_r, win_busy_s};
        IDX_SCRATCH: prdata_s = scratch_r;
        IDX_ID:      prdata_s = ID_VALUE;
        default:     prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  // Control, scratch and write-statistics registers.
  always_ff @(posedge FCB_CLK) begin
    if (FCB_RST) begin
      win_en_r   <= 1'b0;
      win_wait_r <= WAIT_RST;
      scratch_r  <= 32'h0000_0000;
      wr_err_r   <= 1'b0;
      wr_count_r <= 16'h0000;
    end else begin
      if (ctrl_hit_s) begin
        win_en_r   <= pwdata_s[0];
        win_wait_r <= pwdata_s[15:8];
      end
      if (scratch_hit_s) begin
        scratch_r <= pwdata_s;
      end
      // A clearing write beats both the increment and a coincident error.
      if (cnt_clr_s) begin
        wr_count_r <= 16'h0000;
        wr_err_r   <= 1'b0;
      end else begin
        if (wr_acc_s && (wr_count_r != 16'hFFFF)) begin
          wr_count_r <= wr_count_r + 16'd1;
        end
        if (err_hit_s) begin
          wr_err_r <= 1'b1;
        end
      end
    end
  end

  // Window-write engine: HOLD for win_wait+1 cycles, then a one-cycle DONE pulse.
  always_ff @(posedge FCB_CLK) begin
    if (FCB_RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      fmask_r    <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_data_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          wr_valid_r <= 1'b0;
          if (win_start_s) begin
            state_r   <= ST_HOLD;
            cnt_r     <= win_wait_r;
            wr_data_r <= pwdata_s;
            fmask_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            fmask_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_r == 8'd0) begin
            state_r    <= ST_DONE;
            fmask_r    <= 1'b0;
            wr_valid_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r - 8'd1;
            fmask_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          fmask_r    <= 1'b0;
          wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign CSR_APBS_prdata                    = prdata_s;
  assign CFG_APBS_fmask_win_write_operation = fmask_r;
  assign CSR_WIN_wr_valid                   = wr_valid_r;
  assign CSR_WIN_wr_data                    = wr_data_r;

endmodule

// File: tb/tb_fcb_csr_regfile.sv
// Self-checking bench for fcb_csr_regfile: APB-style master with PREADY = ~fmask,
// transaction-level register model and a window monitor.
module tb_fcb_csr_regfile;

  localparam logic [31:0] ID_VAL    = 32'hFCB0_0001;
  localparam int          STALL_MAX = 400;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        pwrite;
  logic        penable;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [66:0] bundle;
  logic [31:0] prdata;
  logic        fmask;
  logic        wr_valid;
  logic [31:0] wr_data;

  int n_tests;
  int n_fail;

  // model state
  logic        m_win_en;
  logic [7:0]  m_wait;
  logic [31:0] m_scratch;
  logic        m_err;
  logic [15:0] m_count;
  int          wq_wait[$];
  logic [31:0] wq_data[$];

  assign bundle = {psel, pwrite, penable, paddr, pwdata};

  fcb_csr_regfile #(.ID_VALUE(32'hFCB0_0001), .WAIT_RST(8'd3)) dut (
    .FCB_CLK                            (clk),
    .FCB_RST                            (rst),
    .APBS_CSR_wdata                     (bundle),
    .CSR_APBS_prdata                    (prdata),
    .CFG_APBS_fmask_win_write_operation (fmask),
    .CSR_WIN_wr_valid                   (wr_valid),
    .CSR_WIN_wr_data                    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] idx);
    case (idx)
      6'd0:    return {16'h0000, m_wait, 7'h00, m_win_en};
      6'd1:    return {m_count, 14'h0000, m_err, 1'b0};
      6'd2:    return m_scratch;
      6'd4:    return ID_VAL;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic model_bump();
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
  endtask

  task automatic model_write(input logic [5:0] idx, input logic [31:0] d);
    if (idx == 6'd0) begin
      m_win_en = d[0];
      m_wait   = d[15:8];
      if (d[1]) begin
        m_count = 16'h0000;
        m_err   = 1'b0;
      end else begin
        model_bump();
      end
    end else begin
      model_bump();
      if (idx == 6'd2) m_scratch = d;
      else if (idx == 6'd3 && m_win_en) begin
        wq_wait.push_back(int'(m_wait));
        wq_data.push_back(d);
      end else m_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_win_en  = 1'b0;
    m_wait    = 8'd3;
    m_scratch = 32'h0000_0000;
    m_err     = 1'b0;
    m_count   = 16'h0000;
  endtask

  // All APB tasks start and end one time unit after a rising edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    int stall;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    @(posedge clk); #1 penable = 1'b1;
    stall = 0;
    @(negedge clk);
    while (fmask === 1'b1 && stall < STALL_MAX) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= STALL_MAX) check_val("apb_wr_ready_bound", {31'h0, fmask}, 32'h0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_write(addr[7:2], data);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output int stall);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr; pwdata = 32'h0;
    @(posedge clk); #1 penable = 1'b1;
    stall = 0;
    @(negedge clk);
    while (fmask === 1'b1 && stall < STALL_MAX) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= STALL_MAX) check_val("apb_rd_ready_bound", {31'h0, fmask}, 32'h0);
    data = prdata;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic chk_read(input logic [31:0] addr, input string tag);
    logic [31:0] d;
    int          s;
    apb_read(addr, d, s);
    check_val(tag, d, model_read(addr[7:2]));
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wq_wait.delete();
    wq_data.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Window monitor: each falling mask edge must carry exactly the expected pulse.
  logic prev_fmask;
  int   run;
  initial begin
    prev_fmask = 1'b0;
    run        = 0;
  end
  always @(negedge clk) begin
    int          w;
    logic [31:0] d;
    if (fmask === 1'b1) begin
      run = run + 1;
    end else begin
      if (prev_fmask) begin
        if (wq_wait.size() > 0) begin
          w = wq_wait.pop_front();
          d = wq_data.pop_front();
          check_val("win_hold_len", run, w + 1);
          check_val("win_valid", {31'h0, wr_valid}, 32'h1);
          check_val("win_data", wr_data, d);
        end else begin
          check_val("win_abort_no_valid", {31'h0, wr_valid}, 32'h0);
        end
      end else if (wr_valid !== 1'b0) begin
        check_val("win_valid_spurious", {31'h0, wr_valid}, 32'h0);
      end
      run = 0;
    end
    prev_fmask = fmask;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [5:0]  idx;
    int          s;
    n_tests = 0;
    n_fail  = 0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    do_reset();

    // reset state
    @(negedge clk);
    check_val("rst_fmask", {31'h0, fmask}, 32'h0);
    check_val("rst_valid", {31'h0, wr_valid}, 32'h0);
    check_val("rst_wdata", wr_data, 32'h0);
    @(posedge clk); #1;
    apb_read(32'h10, d, s); check_val("rst_id", d, 32'hFCB0_0001);
    apb_read(32'h00, d, s); check_val("rst_ctrl", d, 32'h0000_0300);
    apb_read(32'h04, d, s); check_val("rst_status", d, 32'h0);
    paddr = 32'h10; psel = 1'b0;
    @(negedge clk); check_val("psel0_prdata", prdata, 32'h0);
    @(posedge clk); #1;

    // scratch
    apb_write(32'h08, 32'hA5A5_5A5A);
    apb_read(32'h08, d, s); check_val("scratch_rb", d, 32'hA5A5_5A5A);
    apb_read(32'h04, d, s); check_val("status_cnt1", d, 32'h0001_0000);

    // window with read stalled during HOLD
    apb_write(32'h00, 32'h0000_0501);
    apb_write(32'h0C, 32'hDEAD_BEEF);
    apb_read(32'h08, d, s);
    check_val("hold_read_stall", s, 5);
    check_val("hold_read_data", d, 32'hA5A5_5A5A);
    repeat (3) @(posedge clk); #1;
    check_val("win_wdata_hold", wr_data, 32'hDEAD_BEEF);

    // error writes and clear
    apb_write(32'h00, 32'h0000_0503);
    apb_write(32'h04, 32'hFFFF_FFFF);
    apb_write(32'h20, 32'h1234_5678);
    apb_read(32'h04, d, s); check_val("err_status", d, 32'h0002_0002);
    apb_read(32'h08, d, s); check_val("err_scratch", d, 32'hA5A5_5A5A);
    apb_read(32'h00, d, s); check_val("err_ctrl", d, 32'h0000_0501);
    apb_write(32'h00, 32'h0000_0002);
    apb_read(32'h04, d, s); check_val("clr_status", d, 32'h0);

    // window write while disabled
    apb_write(32'h0C, 32'h0BAD_0BAD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_val("dis_no_mask", {31'h0, fmask}, 32'h0);
    end
    @(posedge clk); #1;
    apb_read(32'h04, d, s); check_val("dis_status", d, 32'h0001_0002);

    // back-to-back windows, second accepted in DONE
    apb_write(32'h00, 32'h0000_0201);
    apb_write(32'h0C, 32'h1111_1111);
    apb_write(32'h0C, 32'h2222_2222);
    apb_write(32'h0C, 32'h3333_3333);
    chk_read(32'h04, "b2b_status");

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) idx = 6'($urandom_range(0, 63));
      else idx = 6'($urandom_range(0, 4));
      a = $urandom;
      a[7:2] = idx;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        if (idx == 6'd0) begin
          d[15:8] = 8'($urandom_range(0, 4));
          d[1]    = ($urandom_range(0, 7) == 0);
        end
        apb_write(a, d);
      end else begin
        chk_read(a, "rand_read");
      end
    end
    repeat (20) @(posedge clk); #1;
    chk_read(32'h04, "rand_status");

    // saturation: PSEL/PENABLE/PWRITE held so every cycle is one accepted write
    psel = 1'b1; pwrite = 1'b1; penable = 1'b1; paddr = 32'h08; pwdata = 32'h1234_5678;
    repeat (65540) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    for (int i = 0; i < 65540; i++) model_bump();
    m_scratch = 32'h1234_5678;
    apb_read(32'h04, d, s); check_val("sat_count", {16'h0, d[31:16]}, 32'h0000_FFFF);
    check_val("sat_status", d, model_read(6'd1));
    chk_read(32'h08, "sat_scratch");

    // reset during the second HOLD cycle
    apb_write(32'h00, 32'h0000_0501);
    apb_write(32'h0C, 32'h5555_AAAA);
    @(posedge clk); #1 rst = 1'b1;
    wq_wait.delete();
    wq_data.delete();
    @(negedge clk); check_val("rst_mid_mask_pre", {31'h0, fmask}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_mask", {31'h0, fmask}, 32'h0);
    check_val("rst_mid_valid", {31'h0, wr_valid}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (10) @(posedge clk); #1;
    apb_read(32'h00, d, s); check_val("rst_mid_ctrl", d, 32'h0000_0300);
    apb_read(32'h04, d, s); check_val("rst_mid_status", d, 32'h0);
    apb_read(32'h08, d, s); check_val("rst_mid_scratch", d, 32'h0);
    check_val("rst_mid_wdata", wr_data, 32'h0);

    repeat (10) @(posedge clk); #1;
    check_val("win_queue_drained", wq_wait.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
